lm2_tpgen: RTL and testbench

- Parametrised timing-pulse generator for the LM-2 processor, the next generation of the fixed-speed LM-2 clock block.
- Runs from a single fast oscillator clock. Produces per-microcycle enables and phase strobes: machine clock, CPU clock, write pulse, tri-state enable and IRAM write enable.
- Microcycle length is selectable per cycle by speed code and long-instruction flag. Adds a hang stretch and single-step mode.
- Sits between the board oscillator and the CPU datapath and control-memory write logic.

---
 rtl/lm2_pkg.sv | 43 ++++
 rtl/lm2_tpgen_if.sv | 29 ++
 rtl/lm2_tp_decode.sv | 37 +++
 rtl/lm2_tpgen.sv | 86 ++++++++
 tb/tb_lm2_tpgen.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/lm2_pkg.sv
// Shared speed codes, default microcycle lengths and length selection for the LM-2 timing generator.
package lm2_pkg;

  localparam logic [1:0] SPD_SLOW  = 2'd0;
  localparam logic [1:0] SPD_MID   = 2'd1;
  localparam logic [1:0] SPD_QUICK = 2'd2;
  localparam logic [1:0] SPD_FAST  = 2'd3;

  localparam int DEF_CNT_W      = 4;
  localparam int DEF_LEN_S0     = 8;
  localparam int DEF_LEN_S1     = 6;
  localparam int DEF_LEN_S2     = 5;
  localparam int DEF_LEN_S3     = 4;
  localparam int DEF_LONG_EXTRA = 2;
  localparam int DEF_MAX_LEN    = 2 ** DEF_CNT_W;

  // Microcycle length for a speed code, stretched for long instructions and
  // clamped so it always fits the phase counter of the instantiating block.
  function automatic int unsigned len_sel(
    input logic [1:0]  speed,
    input logic        ilong,
    input int unsigned s0      = DEF_LEN_S0,
    input int unsigned s1      = DEF_LEN_S1,
    input int unsigned s2      = DEF_LEN_S2,
    input int unsigned s3      = DEF_LEN_S3,
    input int unsigned extra   = DEF_LONG_EXTRA,
    input int unsigned max_len = DEF_MAX_LEN
  );
    int unsigned base;
    int unsigned sum;
    base = s0;
    case (speed)
      SPD_SLOW:  base = s0;
      SPD_MID:   base = s1;
      SPD_QUICK: base = s2;
      SPD_FAST:  base = s3;
      default:   base = s0;
    endcase
    sum = base + (ilong ? extra : 0);
    return (sum > max_len) ? max_len : sum;
  endfunction

endpackage

// File: rtl/lm2_tpgen_if.sv
// Control inputs and timing outputs of the LM-2 timing-pulse generator.
interface lm2_tpgen_if #(
  parameter int CNT_W = 4
);
  logic [1:0]       speed;
  logic             ilong;
  logic             run;
  logic             step;
  logic             hang;
  logic             iwrite;
  logic [CNT_W-1:0] ph;
  logic             tpclk;
  logic             mclk_en;
  logic             clk_en;
  logic             wp;
  logic             tse;
  logic             iwe;
  logic             cycle_exec;

  modport master (
    output speed, ilong, run, step, hang, iwrite,
    input  ph, tpclk, mclk_en, clk_en, wp, tse, iwe, cycle_exec
  );

  modport slave (
    input  speed, ilong, run, step, hang, iwrite,
    output ph, tpclk, mclk_en, clk_en, wp, tse, iwe, cycle_exec
  );
endinterface

// File: rtl/lm2_tp_decode.sv
// Phase decode: turns the registered phase, cycle length and execute flag into
// the microcycle clock level, write pulse, tri-state enable and IRAM write enable.
module lm2_tp_decode #(
  parameter int CNT_W     = 4,
  parameter int WP_START  = 1,
  parameter int WP_LEN    = 2,
  parameter int TSE_START = 2
) (
  input  logic [CNT_W-1:0] ph,
  input  logic [CNT_W:0]   len_q,
  input  logic             cycle_exec,
  input  logic             iwrite,
  output logic             tpclk,
  output logic             wp,
  output logic             tse,
  output logic             iwe
);
  localparam int LW = CNT_W + 1;
  localparam logic [LW-1:0] WP_LO  = LW'(WP_START);
  localparam logic [LW-1:0] WP_HI  = LW'(WP_START + WP_LEN);
  localparam logic [LW-1:0] TSE_LO = LW'(TSE_START);

  logic [LW-1:0] ph_x;
  logic [LW-1:0] last;

  // Compare in CNT_W+1 bits so a full 2^CNT_W length does not wrap.
  assign ph_x = {1'b0, ph};
  assign last = len_q - LW'(1);

  // First half of the microcycle drives the clock level high.
  assign tpclk = ph_x < (len_q >> 1);

  // Write pulse is kept off the last phase, which also covers the hang hold.
  assign wp  = cycle_exec && (ph_x >= WP_LO) && (ph_x < WP_HI) && (ph_x < last);
  assign tse = cycle_exec && (ph_x >= TSE_LO);
  assign iwe = wp && iwrite;
endmodule

// File: rtl/lm2_tpgen.sv
// LM-2 timing-pulse generator: variable-length microcycle phase counter with
// hang stretch and single-step, plus end-of-cycle enables and phase strobes.
module lm2_tpgen
  import lm2_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LEN_S0     = DEF_LEN_S0,
  parameter int LEN_S1     = DEF_LEN_S1,
  parameter int LEN_S2     = DEF_LEN_S2,
  parameter int LEN_S3     = DEF_LEN_S3,
  parameter int LONG_EXTRA = DEF_LONG_EXTRA,
  parameter int WP_START   = 1,
  parameter int WP_LEN     = 2,
  parameter int TSE_START  = 2
) (
  input logic        clk,
  input logic        reset_n,
  lm2_tpgen_if.slave bus
);
  localparam int LW      = CNT_W + 1;
  localparam int MAX_LEN = 2 ** CNT_W;
  localparam logic [LW-1:0] LEN_RST = LW'(LEN_S0);

  logic [CNT_W-1:0] ph_q;
  logic [LW-1:0]    len_q;
  logic [LW-1:0]    ph_x;
  logic [LW-1:0]    last;
  logic             cycle_exec_q;
  logic             step_pend;
  logic             ends;

  assign ph_x = {1'b0, ph_q};
  assign last = len_q - LW'(1);
  assign ends = (ph_x == last) && !bus.hang;

  // Phase counter: wraps at the end of a cycle, holds on the last phase while hung.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q <= '0;
    end else if (ends) begin
      ph_q <= '0;
    end else if (ph_x < last) begin
      ph_q <= ph_q + CNT_W'(1);
    end
  end

  // Per-cycle state: next length and execute decision are taken only at the cycle boundary;
  // a step seen while halted is remembered until the boundary consumes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q        <= LEN_RST;
      cycle_exec_q <= 1'b0;
      step_pend    <= 1'b0;
    end else if (ends) begin
      len_q        <= LW'(len_sel(bus.speed, bus.ilong, LEN_S0, LEN_S1, LEN_S2, LEN_S3,
                                  LONG_EXTRA, MAX_LEN));
      cycle_exec_q <= bus.run | step_pend | bus.step;
      if (!bus.run) begin
        step_pend <= 1'b0;
      end
    end else if (bus.step && !bus.run) begin
      step_pend <= 1'b1;
    end
  end

  assign bus.ph         = ph_q;
  assign bus.mclk_en    = ends;
  assign bus.clk_en     = ends && cycle_exec_q;
  assign bus.cycle_exec = cycle_exec_q;

  lm2_tp_decode #(
    .CNT_W     (CNT_W),
    .WP_START  (WP_START),
    .WP_LEN    (WP_LEN),
    .TSE_START (TSE_START)
  ) u_decode (
    .ph         (ph_q),
    .len_q      (len_q),
    .cycle_exec (cycle_exec_q),
    .iwrite     (bus.iwrite),
    .tpclk      (bus.tpclk),
    .wp         (bus.wp),
    .tse        (bus.tse),
    .iwe        (bus.iwe)
  );
endmodule

// File: tb/tb_lm2_tpgen.sv
// Bench for lm2_tpgen: per-tick vector table plus hand sequences for async reset.
module tb_lm2_tpgen;
  import lm2_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  lm2_tpgen_if #(.CNT_W(4)) bus ();

  lm2_tpgen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // exp = {ph[3:0], tpclk, mclk_en, clk_en, wp, tse, iwe, cycle_exec}
  typedef struct {
    logic       run;
    logic [1:0] spd;
    logic       il;
    logic       st;
    logic       hg;
    logic       iw;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void add(bit run, bit [1:0] spd, bit il, bit st, bit hg, bit iw,
                              bit [3:0] ph, bit tp, bit mc, bit ce, bit wp, bit tse,
                              bit iwe, bit ex);
    vec_t v;
    v.run = run; v.spd = spd; v.il = il; v.st = st; v.hg = hg; v.iw = iw;
    v.exp = {ph, tp, mc, ce, wp, tse, iwe, ex};
    vecs.push_back(v);
  endfunction

  function automatic logic [10:0] outs();
    return {bus.ph, bus.tpclk, bus.mclk_en, bus.clk_en, bus.wp, bus.tse, bus.iwe,
            bus.cycle_exec};
  endfunction

  task automatic drive(bit run, bit [1:0] spd, bit il, bit st, bit hg, bit iw);
    bus.run = run; bus.speed = spd; bus.ilong = il;
    bus.step = st; bus.hang = hg; bus.iwrite = iw;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    bit found;
    drive(0, 0, 0, 0, 0, 0);

    //  run spd il st hg iw | ph tp mc ce wp tse iwe ex
    // cycle 0: 8 ticks, non-executing; request run at speed 3 on the boundary
    add(0,0,0,0,0,0, 0,1,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 1,1,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 2,1,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 3,1,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 4,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 5,0,0,0,0,0,0,0);
    add(0,0,0,0,0,0, 6,0,0,0,0,0,0,0);
    add(1,3,0,0,0,0, 7,0,1,0,0,0,0,0);
    // cycle 1: speed 3, executing
    add(1,3,0,0,0,0, 0,1,0,0,0,0,0,1);
    add(1,3,0,0,0,0, 1,1,0,0,1,0,0,1);
    add(1,3,0,0,0,0, 2,0,0,0,1,1,0,1);
    add(1,3,0,0,0,0, 3,0,1,1,0,1,0,1);
    // cycle 2: iwrite high, iwe follows wp; switch to speed 2 long at boundary
    add(1,3,0,0,0,1, 0,1,0,0,0,0,0,1);
    add(1,3,0,0,0,1, 1,1,0,0,1,0,1,1);
    add(1,3,0,0,0,1, 2,0,0,0,1,1,1,1);
    add(1,2,1,0,0,1, 3,0,1,1,0,1,0,1);
    // cycle 3: 7 ticks; speed 0 requested mid-cycle does not shorten/extend it
    add(1,2,1,0,0,0, 0,1,0,0,0,0,0,1);
    add(1,2,1,0,0,0, 1,1,0,0,1,0,0,1);
    add(1,2,1,0,0,0, 2,1,0,0,1,1,0,1);
    add(1,0,1,0,0,0, 3,0,0,0,0,1,0,1);
    add(1,0,1,0,0,0, 4,0,0,0,0,1,0,1);
    add(1,0,1,0,0,0, 5,0,0,0,0,1,0,1);
    add(1,0,1,0,0,0, 6,0,1,1,0,1,0,1);
    // cycle 4: speed 0 long = 10 ticks
    add(1,0,1,0,0,0, 0,1,0,0,0,0,0,1);
    add(1,0,1,0,0,0, 1,1,0,0,1,0,0,1);
    add(1,0,1,0,0,0, 2,1,0,0,1,1,0,1);
    add(1,0,1,0,0,0, 3,1,0,0,0,1,0,1);
    add(1,0,1,0,0,0, 4,1,0,0,0,1,0,1);
    add(1,0,1,0,0,0, 5,0,0,0,0,1,0,1);
    add(1,0,1,0,0,0, 6,0,0,0,0,1,0,1);
    add(1,0,1,0,0,0, 7,0,0,0,0,1,0,1);
    add(1,0,1,0,0,0, 8,0,0,0,0,1,0,1);
    add(1,3,0,0,0,0, 9,0,1,1,0,1,0,1);
    // cycle 5: speed 3 with a 3-tick hang on the last phase -> 7 ticks; halt at end
    add(1,3,0,0,0,0, 0,1,0,0,0,0,0,1);
    add(1,3,0,0,0,0, 1,1,0,0,1,0,0,1);
    add(1,3,0,0,0,0, 2,0,0,0,1,1,0,1);
    add(1,3,0,0,1,0, 3,0,0,0,0,1,0,1);
    add(1,3,0,0,1,0, 3,0,0,0,0,1,0,1);
    add(1,3,0,0,1,0, 3,0,0,0,0,1,0,1);
    add(0,3,0,0,0,0, 3,0,1,1,0,1,0,1);
    // cycle 6: halted, two step pulses
    add(0,3,0,1,0,0, 0,1,0,0,0,0,0,0);
    add(0,3,0,0,0,0, 1,1,0,0,0,0,0,0);
    add(0,3,0,1,0,0, 2,0,0,0,0,0,0,0);
    add(0,3,0,0,0,0, 3,0,1,0,0,0,0,0);
    // cycle 7: the single stepped cycle
    add(0,3,0,0,0,0, 0,1,0,0,0,0,0,1);
    add(0,3,0,0,0,0, 1,1,0,0,1,0,0,1);
    add(0,3,0,0,0,0, 2,0,0,0,1,1,0,1);
    add(0,3,0,0,0,0, 3,0,1,1,0,1,0,1);
    // cycle 8: back to non-executing; hang on a non-last phase does not stall
    add(0,3,0,0,0,0, 0,1,0,0,0,0,0,0);
    add(0,3,0,0,1,0, 1,1,0,0,0,0,0,0);
    add(0,3,0,0,0,0, 2,0,0,0,0,0,0,0);
    add(0,3,0,0,0,0, 3,0,1,0,0,0,0,0);

    check("len_sel_clamp", len_sel(2'd0, 1'b1, 15, 6, 5, 4, 2, 16), 32'd16);
    check("len_sel_s2_long", len_sel(2'd2, 1'b1), 32'd7);

    repeat (3) @(negedge clk);
    #1 check("reset_hold", outs(), {4'd0, 1'b1, 6'b0});
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].run, vecs[i].spd, vecs[i].il, vecs[i].st, vecs[i].hg, vecs[i].iw);
      #1 check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Async reset in the middle of an executing cycle at ph 2.
    @(negedge clk);
    drive(1, 3, 0, 0, 0, 1);
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      #1;
      if (bus.ph == 4'd2 && bus.cycle_exec) found = 1'b1;
      else @(negedge clk);
    end
    check("wait_ph2_exec", found, 1);
    check("pre_reset_ph2", outs(), {4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
    reset_n = 1'b0;
    #1 check("reset_async", outs(), {4'd0, 1'b1, 6'b0});

    @(negedge clk);
    reset_n = 1'b1;
    drive(1, 3, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1 check($sformatf("post_rst_ph%0d", i), outs(),
               {4'(i), 1'(i < 4), 1'(i == 7), 5'b0});
    end
    @(negedge clk);
    #1 check("post_rst_exec_ph0", outs(), {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    #1 check("post_rst_exec_ph1", outs(), {4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
